// File: rtl/rf_op_sequencer_pkg.sv
// Shared constants for the register-file operation sequencer: opcodes, FSM states, shift codes.
package rf_op_sequencer_pkg;

    localparam int DATA_W = 16;

    localparam logic [2:0] OP_MOVI = 3'b000;
    localparam logic [2:0] OP_MOV  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_CMP  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_MVN  = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RDA  = 3'd1,
        S_RDB  = 3'd2,
        S_EXEC = 3'd3,
        S_WB   = 3'd4
    } state_e;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

endpackage

// File: rtl/rf_seq_alu.sv
// Combinational ALU for the sequencer; z/n/v always describe A-B so the FSM can latch them on CMP.
module rf_seq_alu
    import rf_op_sequencer_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [2:0]   i_op,
    output logic [W-1:0] o_c,
    output logic         o_z,
    output logic         o_n,
    output logic         o_v
);

    logic [W-1:0] w_diff;

    // Result select plus compare flags derived from the subtraction.
    always_comb begin
        w_diff = i_a - i_b;
        case (i_op)
            OP_ADD:  o_c = i_a + i_b;
            OP_AND:  o_c = i_a & i_b;
            OP_MOV:  o_c = i_b;
            OP_MVN:  o_c = ~i_b;
            OP_CMP:  o_c = w_diff;
            default: o_c = {W{1'b0}};
        endcase
        o_z = (w_diff == {W{1'b0}});
        o_n = w_diff[W-1];
        // Overflow of A-B: operands differ in sign and the result sign differs from A.
        o_v = (i_a[W-1] != i_b[W-1]) && (w_diff[W-1] != i_a[W-1]);
    end

endmodule

// File: rtl/rf_op_sequencer.sv
// Sequences one op at a time through a 1R/1W register file: read Rn, read Rm, execute, write Rd.
// Optional macro SHIFTER_EN enables the B-operand shifter; otherwise the shift port is ignored.
module rf_op_sequencer
    import rf_op_sequencer_pkg::*;
#(
    parameter int W     = DATA_W,
    parameter int IMM_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [2:0]       rd,
    input  logic [2:0]       rn,
    input  logic [2:0]       rm,
    input  logic [IMM_W-1:0] imm,
    input  logic [1:0]       shift,
    output logic [2:0]       rf_readnum,
    input  logic [W-1:0]     rf_data_out,
    output logic [2:0]       rf_writenum,
    output logic             rf_write,
    output logic [W-1:0]     rf_data_in,
    output logic             busy,
    output logic             done,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v
);

    state_e       r_state;
    logic [2:0]   r_op;
    logic [2:0]   r_rd;
    logic [2:0]   r_rm;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [W-1:0] r_c;
    logic [2:0]   r_readnum;
    logic [2:0]   r_writenum;
    logic         r_write;
    logic         r_done;
    logic         r_z;
    logic         r_n;
    logic         r_v;

    logic [W-1:0] w_imm_sext;
    logic [W-1:0] w_b_next;
    logic [W-1:0] w_alu_c;
    logic         w_alu_z;
    logic         w_alu_n;
    logic         w_alu_v;

    assign w_imm_sext = {{(W-IMM_W){imm[IMM_W-1]}}, imm};

`ifdef SHIFTER_EN
    logic [1:0] r_shift;

    function automatic logic [W-1:0] shift_b(input logic [W-1:0] d, input logic [1:0] sh);
        case (sh)
            SH_LSL:  return {d[W-2:0], 1'b0};
            SH_LSR:  return {1'b0, d[W-1:1]};
            SH_ASR:  return {d[W-1], d[W-1:1]};
            default: return d;
        endcase
    endfunction

    assign w_b_next = shift_b(rf_data_out, r_shift);

    // Shift code captured with the op so it survives while inputs change.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift <= SH_NONE;
        end else if ((r_state == S_IDLE) && in_valid) begin
            r_shift <= shift;
        end
    end
`else
    logic w_unused_shift;
    assign w_unused_shift = ^shift;
    assign w_b_next       = rf_data_out;
`endif

    rf_seq_alu #(.W(W)) u_alu (
        .i_a  (r_a),
        .i_b  (r_b),
        .i_op (r_op),
        .o_c  (w_alu_c),
        .o_z  (w_alu_z),
        .o_n  (w_alu_n),
        .o_v  (w_alu_v)
    );

    // Main sequencer FSM with registered register-file controls, done and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_op       <= OP_MOVI;
            r_rd       <= 3'd0;
            r_rm       <= 3'd0;
            r_a        <= {W{1'b0}};
            r_b        <= {W{1'b0}};
            r_c        <= {W{1'b0}};
            r_readnum  <= 3'd0;
            r_writenum <= 3'd0;
            r_write    <= 1'b0;
            r_done     <= 1'b0;
            r_z        <= 1'b0;
            r_n        <= 1'b0;
            r_v        <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_write <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op <= op;
                        r_rd <= rd;
                        r_rm <= rm;
                        case (op)
                            OP_MOVI: begin
                                r_c        <= w_imm_sext;
                                r_writenum <= rd;
                                r_write    <= 1'b1;
                                r_state    <= S_WB;
                            end
                            OP_MOV, OP_MVN: begin
                                r_readnum <= rm;
                                r_state   <= S_RDB;
                            end
                            OP_ADD, OP_AND, OP_CMP: begin
                                r_readnum <= rn;
                                r_state   <= S_RDA;
                            end
                            default: r_done <= 1'b1;
                        endcase
                    end
                end
                S_RDA: begin
                    r_a       <= rf_data_out;
                    r_readnum <= r_rm;
                    r_state   <= S_RDB;
                end
                S_RDB: begin
                    r_b     <= w_b_next;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    if (r_op == OP_CMP) begin
                        r_z     <= w_alu_z;
                        r_n     <= w_alu_n;
                        r_v     <= w_alu_v;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_c        <= w_alu_c;
                        r_writenum <= r_rd;
                        r_write    <= 1'b1;
                        r_state    <= S_WB;
                    end
                end
                S_WB: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign rf_readnum  = r_readnum;
    assign rf_writenum = r_writenum;
    assign rf_write    = r_write;
    assign rf_data_in  = r_c;
    assign done        = r_done;
    assign flag_z      = r_z;
    assign flag_n      = r_n;
    assign flag_v      = r_v;

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Self-checking bench: behavioural 8x16 register file, table of ops with expected results, reset corner case.
module tb_rf_op_sequencer;
    import rf_op_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready;
    logic [2:0]  op, rd, rn, rm;
    logic [7:0]  imm;
    logic [1:0]  shift;
    logic [2:0]  rf_readnum, rf_writenum;
    logic [15:0] rf_data_out, rf_data_in;
    logic        rf_write, busy, done, flag_z, flag_n, flag_v;

    logic [15:0] rf_mem [8];
    logic [15:0] ref_regs [8];
    logic        tb_clr, pre_we;
    logic [2:0]  pre_idx;
    logic [15:0] pre_val;
    int          wr_cnt;
    logic [2:0]  last_wn;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  op, rd, rn, rm;
        logic [7:0]  imm;
        logic [1:0]  sh;
        logic        pre_en;
        logic [2:0]  pre_idx;
        logic [15:0] pre_val;
        int          lat;
        logic        we;
        logic [15:0] res;
        logic [2:0]  flg;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    rf_op_sequencer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rd(rd), .rn(rn), .rm(rm), .imm(imm), .shift(shift),
        .rf_readnum(rf_readnum), .rf_data_out(rf_data_out),
        .rf_writenum(rf_writenum), .rf_write(rf_write), .rf_data_in(rf_data_in),
        .busy(busy), .done(done), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v)
    );

    assign rf_data_out = rf_mem[rf_readnum];

    always @(posedge clk) begin
        if (tb_clr) begin
            for (int i = 0; i < 8; i++) rf_mem[i] <= 16'h0000;
            wr_cnt  <= 0;
            last_wn <= 3'd0;
        end else if (rf_write) begin
            rf_mem[rf_writenum] <= rf_data_in;
            wr_cnt  <= wr_cnt + 1;
            last_wn <= rf_writenum;
        end else if (pre_we) begin
            rf_mem[pre_idx] <= pre_val;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] o, input logic [2:0] d, input logic [2:0] n,
                                input logic [2:0] m, input logic [7:0] im, input logic [1:0] sh,
                                input logic pe, input logic [2:0] pi, input logic [15:0] pv,
                                input int lat, input logic we, input logic [15:0] res,
                                input logic [2:0] flg);
        vec_t v;
        v.op = o; v.rd = d; v.rn = n; v.rm = m; v.imm = im; v.sh = sh;
        v.pre_en = pe; v.pre_idx = pi; v.pre_val = pv;
        v.lat = lat; v.we = we; v.res = res; v.flg = flg;
        return v;
    endfunction

    task automatic preload(input logic [2:0] idx, input logic [15:0] val);
        pre_we  = 1'b1;
        pre_idx = idx;
        pre_val = val;
        @(negedge clk);
        pre_we  = 1'b0;
        ref_regs[idx] = val;
    endtask

    task automatic run_vec(input vec_t v);
        int   n;
        int   wc0;
        vec_t e;
        if (v.pre_en) preload(v.pre_idx, v.pre_val);
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        op = v.op; rd = v.rd; rn = v.rn; rm = v.rm; imm = v.imm; shift = v.sh;
        in_valid = 1'b1;
        wc0 = wr_cnt;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 3'($urandom); rd = 3'($urandom); rn = 3'($urandom); rm = 3'($urandom);
        imm = 8'($urandom); shift = 2'($urandom);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) chk("busy_after_accept", {31'd0, busy}, (v.lat > 1) ? 32'd1 : 32'd0);
            if (done) break;
        end
        e = exp_q.pop_front();
        chk("latency", n, e.lat);
        chk("write_count", wr_cnt - wc0, e.we ? 32'd1 : 32'd0);
        if (e.we) begin
            chk("writenum", {29'd0, last_wn}, {29'd0, e.rd});
            ref_regs[e.rd] = e.res;
        end
        chk("flags_znv", {29'd0, flag_z, flag_n, flag_v}, {29'd0, e.flg});
        for (int i = 0; i < 8; i++) chk("regfile", {16'd0, rf_mem[i]}, {16'd0, ref_regs[i]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] e_asr, e_lsr, e_lsl, e_add;
        int          dn;
        int          wc0;
`ifdef SHIFTER_EN
        e_asr = 16'hC001; e_lsr = 16'h4001; e_lsl = 16'h0004; e_add = 16'h8006;
`else
        e_asr = 16'h8002; e_lsr = 16'h8002; e_lsl = 16'h8002; e_add = 16'h0004;
`endif
        //          op       rd    rn    rm    imm    sh     pre               lat we   result     znv
        vecs.push_back(mk(OP_MOVI, 3'd3, 3'd0, 3'd0, 8'hF0, 2'b00, 1'b0, 3'd0, 16'h0, 2, 1'b1, 16'hFFF0, 3'b000));
        vecs.push_back(mk(OP_ADD,  3'd4, 3'd1, 3'd2, 8'h00, 2'b00, 1'b0, 3'd0, 16'h0, 5, 1'b1, 16'h8000, 3'b000));
        vecs.push_back(mk(OP_CMP,  3'd0, 3'd4, 3'd4, 8'h00, 2'b00, 1'b0, 3'd0, 16'h0, 4, 1'b0, 16'h0000, 3'b100));
        vecs.push_back(mk(OP_ADD,  3'd1, 3'd4, 3'd0, 8'h00, 2'b00, 1'b0, 3'd0, 16'h0, 5, 1'b1, 16'h8000, 3'b100));
        vecs.push_back(mk(OP_CMP,  3'd0, 3'd1, 3'd2, 8'h00, 2'b00, 1'b0, 3'd0, 16'h0, 4, 1'b0, 16'h0000, 3'b001));
        vecs.push_back(mk(OP_AND,  3'd7, 3'd3, 3'd1, 8'h00, 2'b00, 1'b0, 3'd0, 16'h0, 5, 1'b1, 16'h8000, 3'b001));
        vecs.push_back(mk(OP_MVN,  3'd6, 3'd0, 3'd2, 8'h00, 2'b00, 1'b0, 3'd0, 16'h0, 4, 1'b1, 16'hFFFE, 3'b001));
        vecs.push_back(mk(OP_MOV,  3'd0, 3'd0, 3'd3, 8'h00, 2'b00, 1'b0, 3'd0, 16'h0, 4, 1'b1, 16'hFFF0, 3'b001));
        vecs.push_back(mk(3'b111,  3'd2, 3'd1, 3'd1, 8'h55, 2'b00, 1'b0, 3'd0, 16'h0, 1, 1'b0, 16'h0000, 3'b001));
        vecs.push_back(mk(3'b110,  3'd3, 3'd2, 3'd2, 8'hAA, 2'b00, 1'b0, 3'd0, 16'h0, 1, 1'b0, 16'h0000, 3'b001));
        vecs.push_back(mk(OP_MOVI, 3'd1, 3'd0, 3'd0, 8'h03, 2'b00, 1'b0, 3'd0, 16'h0, 2, 1'b1, 16'h0003, 3'b001));
        vecs.push_back(mk(OP_ADD,  3'd1, 3'd1, 3'd1, 8'h00, 2'b00, 1'b0, 3'd0, 16'h0, 5, 1'b1, 16'h0006, 3'b001));
        vecs.push_back(mk(OP_CMP,  3'd0, 3'd2, 3'd1, 8'h00, 2'b00, 1'b0, 3'd0, 16'h0, 4, 1'b0, 16'h0000, 3'b010));
        vecs.push_back(mk(OP_MOV,  3'd6, 3'd0, 3'd2, 8'h00, 2'b11, 1'b1, 3'd2, 16'h8002, 4, 1'b1, e_asr, 3'b010));
        vecs.push_back(mk(OP_MOV,  3'd6, 3'd0, 3'd2, 8'h00, 2'b10, 1'b0, 3'd0, 16'h0, 4, 1'b1, e_lsr, 3'b010));
        vecs.push_back(mk(OP_MOV,  3'd5, 3'd0, 3'd2, 8'h00, 2'b01, 1'b0, 3'd0, 16'h0, 4, 1'b1, e_lsl, 3'b010));
        vecs.push_back(mk(OP_ADD,  3'd7, 3'd2, 3'd2, 8'h00, 2'b01, 1'b0, 3'd0, 16'h0, 5, 1'b1, e_add, 3'b010));

        reset = 1'b1; tb_clr = 1'b1; pre_we = 1'b0; pre_idx = 3'd0; pre_val = 16'h0;
        in_valid = 1'b0; op = 3'd0; rd = 3'd0; rn = 3'd0; rm = 3'd0; imm = 8'h00; shift = 2'b00;
        for (int i = 0; i < 8; i++) ref_regs[i] = 16'h0000;
        repeat (3) @(negedge clk);
        reset = 1'b0; tb_clr = 1'b0;

        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rf_write", {31'd0, rf_write}, 32'd0);
        chk("rst_flags", {29'd0, flag_z, flag_n, flag_v}, 32'd0);
        chk("rst_readnum", {29'd0, rf_readnum}, 32'd0);
        chk("rst_writenum", {29'd0, rf_writenum}, 32'd0);
        chk("rst_data_in", {16'd0, rf_data_in}, 32'd0);

        run_vec(vecs[0]);
        preload(3'd1, 16'h7FFF);
        preload(3'd2, 16'h0001);
        for (int i = 1; i < vecs.size(); i++) run_vec(vecs[i]);

        // Reset while an ADD to R5 sits in RDB: no write, no done, flags cleared.
        preload(3'd5, 16'h1234);
        wc0 = wr_cnt;
        op = OP_ADD; rd = 3'd5; rn = 3'd1; rm = 3'd2; shift = 2'b00; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_op_in_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_flags", {29'd0, flag_z, flag_n, flag_v}, 32'd0);
        chk("rst_mid_rf_write", {31'd0, rf_write}, 32'd0);
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) dn++;
            @(negedge clk);
        end
        chk("rst_mid_no_done", dn, 32'd0);
        chk("rst_mid_no_write", wr_cnt - wc0, 32'd0);
        chk("rst_mid_r5", {16'd0, rf_mem[5]}, 32'h1234);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
